// File: rtl/tristate_release_monitor.sv
// Checks a dual-rail tri-state bus against its enable: driven bits must be defined, released bits undefined.
// Define TRISTATE_MON_FORMAL_EN to add immediate assertions and covers on the violation flag and FSM.
module tristate_release_monitor #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_condition,
    input  logic [WIDTH-1:0] bus_lo,
    input  logic [WIDTH-1:0] bus_hi,
    output logic [WIDTH-1:0] undef_mask,
    output logic             violation,
    output logic             err_sticky,
    output logic [CNT_W-1:0] viol_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        DRIVEN    = 2'b00,
        RELEASING = 2'b01,
        RELEASED  = 2'b10,
        UNUSED    = 2'b11
    } stateT;

    localparam logic [3:0]       SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    stateT            stateQ, stateD;
    logic [3:0]       settleQ, settleD;
    logic [WIDTH-1:0] undefQ;
    logic             violQ, violD;
    logic             stickyQ;
    logic [CNT_W-1:0] countQ, countD;

    logic [WIDTH-1:0] undefBits;
    logic [WIDTH-1:0] illegalBits;

    assign undefBits   = ~bus_lo & bus_hi;
    assign illegalBits = bus_lo & ~bus_hi;

    // Checks use the state held before the edge; a high enable overrides everything.
    always_comb begin
        stateD  = stateQ;
        settleD = settleQ;
        violD   = |illegalBits;
        case (stateQ)
            DRIVEN: begin
                if (enable_condition) begin
                    violD = violD | (|undefBits);
                end else if (SETTLE > 0) begin
                    stateD  = RELEASING;
                    settleD = SETTLE_LOAD;
                end else begin
                    stateD = RELEASED;
                end
            end
            RELEASING: begin
                if (!enable_condition) begin
                    if (settleQ == 4'd0) begin
                        stateD = RELEASED;
                    end else begin
                        settleD = settleQ - 4'd1;
                    end
                end
            end
            RELEASED: begin
                if (!enable_condition) begin
                    violD = violD | (|(~undefBits));
                end
            end
            default: stateD = DRIVEN;
        endcase
        if (enable_condition) begin
            stateD = DRIVEN;
        end
    end

    assign countD = (violD && (countQ != CNT_MAX)) ? countQ + 1'b1 : countQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ  <= DRIVEN;
            settleQ <= 4'd0;
            undefQ  <= '0;
            violQ   <= 1'b0;
            stickyQ <= 1'b0;
            countQ  <= '0;
        end else begin
            stateQ  <= stateD;
            settleQ <= settleD;
            undefQ  <= undefBits;
            violQ   <= violD;
            stickyQ <= stickyQ | violD;
            countQ  <= countD;
        end
    end

    assign undef_mask = undefQ;
    assign violation  = violQ;
    assign err_sticky = stickyQ;
    assign viol_count = countQ;
    assign state      = stateQ;

`ifdef TRISTATE_MON_FORMAL_EN
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!violation);
            cover (stateQ == RELEASED);
            cover ((stateQ == RELEASED) && enable_condition);
        end
    end
`endif

endmodule

// File: tb/tb_tristate_release_monitor.sv
// Directed scoreboard bench: expectations are queued with each stimulus step and popped after the edge.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_tristate_release_monitor;

    logic       clk;
    logic       rst_n;
    logic       enable_condition;
    logic [7:0] bus_lo;
    logic [7:0] bus_hi;

    logic [7:0] undefMask;
    logic       violation;
    logic       errSticky;
    logic [7:0] violCount;
    logic [1:0] state;

    logic [7:0] undefMask2;
    logic       violation2;
    logic       errSticky2;
    logic [1:0] violCount2;
    logic [1:0] state2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       viol;
        logic [7:0] mask;
        logic [7:0] cnt;
        logic       sticky;
    } expT;

    expT sbQ[$];

    tristate_release_monitor #(.WIDTH(8), .SETTLE(2), .CNT_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable_condition (enable_condition),
        .bus_lo           (bus_lo),
        .bus_hi           (bus_hi),
        .undef_mask       (undefMask),
        .violation        (violation),
        .err_sticky       (errSticky),
        .viol_count       (violCount),
        .state            (state)
    );

    tristate_release_monitor #(.WIDTH(8), .SETTLE(2), .CNT_W(2)) dutSat (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable_condition (enable_condition),
        .bus_lo           (bus_lo),
        .bus_hi           (bus_hi),
        .undef_mask       (undefMask2),
        .violation        (violation2),
        .err_sticky       (errSticky2),
        .viol_count       (violCount2),
        .state            (state2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        expT e;
        logic [1:0] satCnt;
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sbQ.pop_front();
        satCnt = (e.cnt > 8'd3) ? 2'd3 : e.cnt[1:0];
        compare({e.tag, ".state"},     64'(state),      64'(e.st));
        compare({e.tag, ".violation"}, 64'(violation),  64'(e.viol));
        compare({e.tag, ".undef_mask"},64'(undefMask),  64'(e.mask));
        compare({e.tag, ".viol_count"},64'(violCount),  64'(e.cnt));
        compare({e.tag, ".err_sticky"},64'(errSticky),  64'(e.sticky));
        compare({e.tag, ".sat_count"}, 64'(violCount2), 64'(satCnt));
        compare({e.tag, ".sat_viol"},  64'(violation2), 64'(e.viol));
    endtask

    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic [7:0] lo, input logic [7:0] hi,
                                 input logic [1:0] st, input logic viol,
                                 input logic [7:0] mask, input logic [7:0] cnt,
                                 input logic sticky, input string tag);
        expT e;
        rst_n            = rst;
        enable_condition = en;
        bus_lo           = lo;
        bus_hi           = hi;
        e.tag    = tag;
        e.st     = st;
        e.viol   = viol;
        e.mask   = mask;
        e.cnt    = cnt;
        e.sticky = sticky;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n            = 1'b0;
        enable_condition = 1'b1;
        bus_lo           = 8'h00;
        bus_hi           = 8'h00;

        //            rst  en  lo     hi     st     v  mask   cnt  stk  tag
        applyStimulus(0, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'd0, 0, "reset0");
        applyStimulus(0, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'd0, 0, "reset1");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 8'hA5, 8'hA5, 2'b00, 0, 8'h00, 8'd0, 0, "driven_ok");
        end

        // Release with SETTLE=2: two RELEASING cycles, then RELEASED.
        applyStimulus(1, 0, 8'hA5, 8'hA5, 2'b01, 0, 8'h00, 8'd0, 0, "release_enter");
        applyStimulus(1, 0, 8'h00, 8'hFF, 2'b01, 0, 8'hFF, 8'd0, 0, "releasing");
        applyStimulus(1, 0, 8'h00, 8'hFF, 2'b10, 0, 8'hFF, 8'd0, 0, "released_enter");
        applyStimulus(1, 0, 8'h00, 8'hFF, 2'b10, 0, 8'hFF, 8'd0, 0, "released_ok");

        applyStimulus(1, 0, 8'h08, 8'hFF, 2'b10, 1, 8'hF7, 8'd1, 1, "released_defined_bit");
        applyStimulus(1, 0, 8'h00, 8'hFF, 2'b10, 0, 8'hFF, 8'd1, 1, "released_recover");

        // Re-enable: RELEASED sampled with enable high checks only illegal bits.
        applyStimulus(1, 1, 8'hA5, 8'hA5, 2'b00, 0, 8'h00, 8'd1, 1, "reenable");
        applyStimulus(1, 1, 8'hA5, 8'hA5, 2'b00, 0, 8'h00, 8'd1, 1, "driven_again");

        applyStimulus(1, 1, 8'h10, 8'h00, 2'b00, 1, 8'h00, 8'd2, 1, "driven_illegal");
        applyStimulus(1, 0, 8'hA5, 8'hA5, 2'b01, 0, 8'h00, 8'd2, 1, "release_enter2");
        applyStimulus(1, 0, 8'h10, 8'h00, 2'b01, 1, 8'h00, 8'd3, 1, "releasing_illegal");
        applyStimulus(1, 0, 8'h00, 8'hFF, 2'b10, 0, 8'hFF, 8'd3, 1, "released_enter2");

        // Fresh reset, then five back-to-back violations to saturate the 2-bit counter.
        applyStimulus(0, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'd0, 0, "reset2");
        applyStimulus(1, 1, 8'h00, 8'h01, 2'b00, 1, 8'h01, 8'd1, 1, "driven_undef");
        applyStimulus(1, 1, 8'h10, 8'h00, 2'b00, 1, 8'h00, 8'd2, 1, "sat2");
        applyStimulus(1, 1, 8'h10, 8'h00, 2'b00, 1, 8'h00, 8'd3, 1, "sat3");
        applyStimulus(1, 1, 8'h10, 8'h00, 2'b00, 1, 8'h00, 8'd4, 1, "sat4");
        applyStimulus(1, 1, 8'h10, 8'h00, 2'b00, 1, 8'h00, 8'd5, 1, "sat5");
        applyStimulus(1, 1, 8'hA5, 8'hA5, 2'b00, 0, 8'h00, 8'd5, 1, "sat_quiet");

        // Reset one cycle into RELEASING with an illegal bus: nothing reported.
        applyStimulus(1, 0, 8'hA5, 8'hA5, 2'b01, 0, 8'h00, 8'd5, 1, "release_enter3");
        applyStimulus(0, 0, 8'h10, 8'h00, 2'b00, 0, 8'h00, 8'd0, 0, "reset_mid_release");
        applyStimulus(1, 1, 8'hA5, 8'hA5, 2'b00, 0, 8'h00, 8'd0, 0, "after_reset");
        applyStimulus(1, 1, 8'h10, 8'h00, 2'b00, 1, 8'h00, 8'd1, 1, "first_check");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tristate_release_monitor.md
TRISTATE_RELEASE_MONITOR -- requirements
Module: tristate_release_monitor

Interface
REQ-001 Parameter WIDTH, default 8: number of monitored bus bits; legal range 1..64.
REQ-002 Parameter SETTLE, default 2: number of grace cycles after enable deassertion; legal range 0..15.
REQ-003 Parameter CNT_W, default 8: width of the violation counter; legal range 1..32.
REQ-004 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n  in  1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-006 Port enable_condition  in  1: high means the bus is driven; low means the bus is released.
REQ-007 Port bus_lo  in  WIDTH: dual-rail bus copy resolved with undefined bits forced to 0.
REQ-008 Port bus_hi  in  WIDTH: dual-rail bus copy resolved with undefined bits forced to 1.
REQ-009 Port undef_mask  out  WIDTH: registered per-bit flag, 1 where bus_lo=0 and bus_hi=1.
REQ-010 Port violation  out  1: registered one-cycle pulse on any rule breach.
REQ-011 Port err_sticky  out  1: set by violation, cleared only by reset.
REQ-012 Port viol_count  out  CNT_W: saturating count of violation pulses.
REQ-013 Port state  out  2: current FSM state encoding.

Function
REQ-014 The per-bit classification SHALL be: defined when bus_lo==bus_hi; undefined when lo=0 and hi=1; illegal when lo=1 and hi=0.
REQ-015 The FSM SHALL have states DRIVEN=2'b00, RELEASING=2'b01, RELEASED=2'b10; encoding 2'b11 is unreachable and, if entered, SHALL return to DRIVEN on the next cycle.
REQ-016 DRIVEN -> RELEASING when enable_condition=0 and SETTLE>0; DRIVEN -> RELEASED when enable_condition=0 and SETTLE=0.
REQ-017 In RELEASING, the settle counter SHALL load SETTLE-1 on entry, decrement each cycle, and move to RELEASED when it reaches 0 with enable_condition still 0.
REQ-018 Any state SHALL move to DRIVEN in the cycle after enable_condition=1; this takes priority over the settle counter.
REQ-019 In DRIVEN with enable_condition=1, any undefined or illegal bit SHALL raise violation.
REQ-020 In RELEASED with enable_condition=0, any bit not undefined SHALL raise violation.
REQ-021 In RELEASING, only illegal bits SHALL raise violation; undefined/defined mixes are permitted.
REQ-022 Illegal bits SHALL raise violation in every state.
REQ-023 violation and undef_mask SHALL reflect inputs sampled at edge N, visible after edge N, which is a latency of 1 cycle.
REQ-024 Checks SHALL use the state held before the edge; the transition cycle itself is checked against the old state.
REQ-025 viol_count SHALL increment by 1 per violation pulse and hold at 2^CNT_W-1 without wrapping.
REQ-026 A simultaneous violation and saturation SHALL leave viol_count at maximum and still pulse violation.

Reset
REQ-027 On rst_n=0 at a clk edge: state=DRIVEN, settle counter=0, undef_mask=0, violation=0, err_sticky=0, viol_count=0.
REQ-028 Reset mid-RELEASING SHALL abandon the settle window; no violation SHALL be reported in the reset cycle.
REQ-029 The first check SHALL occur on the edge after rst_n returns to 1.

Configuration
REQ-030 Macro TRISTATE_MON_FORMAL_EN defined: the block SHALL contain immediate assertions, active only when rst_n=1, equivalent to violation never being 1; it SHALL also contain cover statements for reaching RELEASED and for returning from RELEASED to DRIVEN.
REQ-031 Macro TRISTATE_MON_FORMAL_EN undefined: no assert or cover statements; ports and flag behaviour are identical.

Verification
REQ-032 WIDTH=8, SETTLE=2; enable=1, lo=hi=8'hA5 for 4 cycles -> violation=0, state=DRIVEN, undef_mask=0.
REQ-033 Drop enable; lo=0, hi=FF from the next cycle -> state 01 for 2 cycles, then 10; violation=0 throughout.
REQ-034 In RELEASED, set bus_lo[3]=1, bus_hi[3]=1 for 1 cycle -> one violation pulse; err_sticky=1; viol_count=1; undef_mask=8'hF7.
REQ-035 In DRIVEN, set lo=8'h10, hi=8'h00 (illegal bit 4) -> violation pulse; same stimulus in RELEASING also pulses.
REQ-036 CNT_W=2; force 5 consecutive violations -> viol_count sequence 1,2,3,3,3.
REQ-037 Assert rst_n=0 one cycle into RELEASING, then release with enable=1 -> all outputs 0 and state=DRIVEN; no violation in the reset cycle.
